fetch_unit: RTL

- Instruction-fetch front end of the pipelined CPU.
- Owns the PC register, issues word reads to instruction memory with a req/ready handshake, and delivers instructions into the IF/ID register.
- Consumes PC redirects (branch/jump/jr targets) from the PC-select logic and stall requests from the hazard unit.
- Flushes wrong-path fetches and buffers one instruction when a stall collides with a returning fetch.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_skid_buf.sv | 32 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
   localparam logic [31:0] PC_STEP          = 32'd4;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {instr,pc} buffer that catches a fetch returning while ID is stalled.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        drain,
   input  logic        flush,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic        full,
   output logic [31:0] instr,
   output logic [31:0] pc
);

   // Capture on load; drain or flush empties the entry. Data is kept on empty.
   always_ff @(posedge clk) begin
      if (!reset) begin
         full  <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (flush || drain) begin
         full <= 1'b0;
      end else if (load) begin
         full  <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, imem req/ready handshake, IF/ID register.
//
// state | meaning
// ------+-----------------------------------------------------------
// FETCH | request outstanding at pc; accept, bubble or redirect
// HOLD  | ID stalled with a fetched word parked in the skid buffer
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic        fetch_err
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic         skid_full;
   logic [31:0]  skid_instr;
   logic [31:0]  skid_pc;
   logic         skid_load;
   logic         skid_drain;
   logic         skid_flush;

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;

   assign skid_load  = (state == FETCH) && !redirect_valid && imem_ready && stall;
   assign skid_drain = (state == HOLD)  && !redirect_valid && !stall;
   assign skid_flush = (state == HOLD)  && redirect_valid;

   fetch_skid_buf u_skid (
      .clk        (clk),
      .reset      (reset),
      .load       (skid_load),
      .drain      (skid_drain),
      .flush      (skid_flush),
      .load_instr (imem_rdata),
      .load_pc    (pc),
      .full       (skid_full),
      .instr      (skid_instr),
      .pc         (skid_pc)
   );

   // PC, FSM, IF/ID register and sticky misalignment flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         id_valid  <= 1'b0;
         id_instr  <= '0;
         id_pc     <= '0;
         id_pc4    <= '0;
         fetch_err <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect beats stall: whatever sits in ID is wrong-path.
         state    <= FETCH;
         pc       <= word_align(redirect_pc);
         id_valid <= 1'b0;
         if (redirect_pc[1:0] != 2'b00) fetch_err <= 1'b1;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready && !stall) begin
                  id_instr <= imem_rdata;
                  id_pc    <= pc;
                  id_pc4   <= pc + PC_STEP;
                  id_valid <= 1'b1;
                  pc       <= pc + PC_STEP;
               end else if (imem_ready) begin
                  pc    <= pc + PC_STEP;
                  state <= HOLD;
               end else if (!stall) begin
                  id_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall && skid_full) begin
                  id_instr <= skid_instr;
                  id_pc    <= skid_pc;
                  id_pc4   <= skid_pc + PC_STEP;
                  id_valid <= 1'b1;
                  state    <= FETCH;
               end else if (!stall) begin
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule
